// File: rtl/noc_ni_tx.sv
// noc_ni_tx: transmit half of a mesh network interface.
// Buffers core messages in a small FIFO and serialises each one into a
// HEAD flit (XY routing info) followed by a TAIL flit (payload) towards
// the router local port over a valid/ready link.
// Optional build macro NOC_NI_PARITY_EN adds an even-parity MSB to every flit.
module noc_ni_tx #(
   parameter int ROWS       = 2,
   parameter int COLS       = 2,
   parameter int DATA_WIDTH = 32,
   parameter int X_ID       = 0,
   parameter int Y_ID       = 0,
   parameter int FIFO_DEPTH = 4,
   localparam int YW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1,
   localparam int XW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
`ifdef NOC_NI_PARITY_EN
   localparam int FW = DATA_WIDTH + 3
`else
   localparam int FW = DATA_WIDTH + 2
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  msg_valid,
   output logic                  msg_ready,
   input  logic [XW-1:0]         msg_dest_x,
   input  logic [YW-1:0]         msg_dest_y,
   input  logic [DATA_WIDTH-1:0] msg_payload,
   output logic [FW-1:0]         flit_out,
   output logic                  flit_valid,
   input  logic                  flit_ready,
   output logic                  busy,
   output logic [15:0]           pkt_sent,
   output logic                  dest_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = XW + YW + DATA_WIDTH;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [1:0] TYPE_HEAD = 2'b01;
   localparam logic [1:0] TYPE_TAIL = 2'b10;

   typedef enum logic [1:0] {IDLE, HEAD, TAIL} state_t;

   state_t                state, state_nxt;
   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count;
   logic                  run;
   logic [DATA_WIDTH-1:0] tail_payload;
   logic [EW-1:0]         rd_entry;
   logic                  empty, full, accept, in_range, push, pop, flit_fire;
   logic                  load_head, load_tail, drop_valid;

   // Assemble a flit from type and data; parity (when built in) makes the whole flit even.
   function automatic logic [FW-1:0] make_flit(input logic [1:0] ftype,
                                              input logic [DATA_WIDTH-1:0] data);
      logic [FW-1:0] f;
`ifdef NOC_NI_PARITY_EN
      f = {1'b0, ftype, data};
      f[FW-1] = ^f[FW-2:0];
`else
      f = {ftype, data};
`endif
      return f;
   endfunction

   // HEAD data: dest x, dest y, src x, src y packed from bit 0 upwards, rest zero.
   function automatic logic [DATA_WIDTH-1:0] head_data(input logic [XW-1:0] dx,
                                                      input logic [YW-1:0] dy);
      logic [DATA_WIDTH-1:0] d;
      d = '0;
      d[XW-1:0]                 = dx;
      d[XW+YW-1:XW]             = dy;
      d[2*XW+YW-1:XW+YW]        = XW'(X_ID);
      d[2*XW+2*YW-1:2*XW+YW]    = YW'(Y_ID);
      return d;
   endfunction

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign msg_ready = run & ~full;
   assign accept    = msg_valid & msg_ready;
   assign in_range  = ({1'b0, msg_dest_x} < (XW+1)'(COLS)) &&
                      ({1'b0, msg_dest_y} < (YW+1)'(ROWS));
   assign push      = accept & in_range;
   assign flit_fire = flit_valid & flit_ready;
   assign rd_entry  = mem[rd_ptr];
   assign busy      = (state != IDLE) | ~empty;

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic: pop on IDLE-with-data or back-to-back after a TAIL handshake.
   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      load_head  = 1'b0;
      load_tail  = 1'b0;
      drop_valid = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               load_head = 1'b1;
               state_nxt = HEAD;
            end
         end
         HEAD: begin
            if (flit_fire) begin
               load_tail = 1'b1;
               state_nxt = TAIL;
            end
         end
         TAIL: begin
            if (flit_fire) begin
               if (!empty) begin
                  pop       = 1'b1;
                  load_head = 1'b1;
                  state_nxt = HEAD;
               end else begin
                  drop_valid = 1'b1;
                  state_nxt  = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FIFO storage; only in-range messages are written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {msg_dest_y, msg_dest_x, msg_payload};
   end

   // Payload of the packet in flight, kept for the TAIL flit.
   always_ff @(posedge clk) begin
      if (load_head) tail_payload <= rd_entry[DATA_WIDTH-1:0];
   end

   // FIFO pointers/count, ready enable, packet counter and sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         run      <= 1'b0;
         pkt_sent <= '0;
         dest_err <= 1'b0;
      end else begin
         run <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if ((state == TAIL) && flit_fire) pkt_sent <= pkt_sent + 16'd1;
         if (accept && !in_range) dest_err <= 1'b1;
      end
   end

   // Output flit register: held stable until the router takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flit_out   <= '0;
         flit_valid <= 1'b0;
      end else if (load_head) begin
         flit_out   <= make_flit(TYPE_HEAD,
                                 head_data(rd_entry[DATA_WIDTH+XW-1:DATA_WIDTH],
                                           rd_entry[EW-1:DATA_WIDTH+XW]));
         flit_valid <= 1'b1;
      end else if (load_tail) begin
         flit_out   <= make_flit(TYPE_TAIL, tail_payload);
      end else if (drop_valid) begin
         flit_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_noc_ni_tx.sv
// Scoreboard bench for noc_ni_tx on a 3x3 mesh (node x=2, y=1) so that
// out-of-range destinations are encodable.
module tb_noc_ni_tx;

   localparam int ROWS = 3;
   localparam int COLS = 3;
   localparam int DATA_WIDTH = 32;
   localparam int X_ID = 2;
   localparam int Y_ID = 1;
   localparam int FIFO_DEPTH = 4;
   localparam int YW = 2;
   localparam int XW = 2;
`ifdef NOC_NI_PARITY_EN
   localparam int FW = DATA_WIDTH + 3;
`else
   localparam int FW = DATA_WIDTH + 2;
`endif

   logic                  clk = 0;
   logic                  rst = 0;
   logic                  msg_valid = 0;
   logic                  msg_ready;
   logic [XW-1:0]         msg_dest_x = 0;
   logic [YW-1:0]         msg_dest_y = 0;
   logic [DATA_WIDTH-1:0] msg_payload = 0;
   logic [FW-1:0]         flit_out;
   logic                  flit_valid;
   logic                  flit_ready = 0;
   logic                  busy;
   logic [15:0]           pkt_sent;
   logic                  dest_err;

   noc_ni_tx #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DATA_WIDTH), .X_ID(X_ID),
               .Y_ID(Y_ID), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .msg_dest_x(msg_dest_x), .msg_dest_y(msg_dest_y), .msg_payload(msg_payload),
      .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
      .busy(busy), .pkt_sent(pkt_sent), .dest_err(dest_err));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_acc = 0;
   logic [FW-1:0] sb[$];
   logic [15:0] exp_pkt = 0;
   logic exp_err = 0;
   logic up = 0;
   logic hold_prev = 0;
   logic [FW-1:0] prev_flit = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference flit: type in the two bits above the data, optional even parity on top.
   function automatic logic [FW-1:0] ref_flit(input logic [1:0] t, input logic [DATA_WIDTH-1:0] d);
      logic [FW-1:0] f;
      f = FW'({t, d});
`ifdef NOC_NI_PARITY_EN
      f[FW-1] = ^{t, d};
`endif
      return f;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] ref_head(input int dx, input int dy);
      return DATA_WIDTH'(dx + (dy << XW) + (X_ID << (XW + YW)) + (Y_ID << (2*XW + YW)));
   endfunction

   always @(posedge clk) up <= rst;

   // Monitor: checks every negedge, predicts the handshakes of the coming posedge.
   always @(negedge clk) begin
      int pkts;
      logic [FW-1:0] f;
      if (!rst || !up) begin
         hold_prev = 0;
      end else begin
         chk("pkt_sent", 64'(pkt_sent), 64'(exp_pkt));
         chk("dest_err", 64'(dest_err), 64'(exp_err));
         chk("busy", 64'(busy), 64'(sb.size() != 0));
         pkts = (sb.size() + 1) / 2;
         if (pkts < FIFO_DEPTH) chk("msg_ready_open", 64'(msg_ready), 64'd1);
         else if (pkts > FIFO_DEPTH) chk("msg_ready_full", 64'(msg_ready), 64'd0);
         if (hold_prev) begin
            chk("hold_valid", 64'(flit_valid), 64'd1);
            chk("hold_data", 64'(flit_out), 64'(prev_flit));
         end
         if (flit_valid && sb.size() == 0) begin
            chk("spurious_flit", 64'(flit_valid), 64'd0);
         end else if (flit_valid && flit_ready) begin
            f = sb.pop_front();
            chk("flit", 64'(flit_out), 64'(f));
            if (f[DATA_WIDTH+1:DATA_WIDTH] == 2'b10) exp_pkt++;
         end
         hold_prev = flit_valid && !flit_ready;
         prev_flit = flit_out;
         if (msg_valid && msg_ready) begin
            n_acc++;
            if (int'(msg_dest_x) < COLS && int'(msg_dest_y) < ROWS) begin
               sb.push_back(ref_flit(2'b01, ref_head(int'(msg_dest_x), int'(msg_dest_y))));
               sb.push_back(ref_flit(2'b10, msg_payload));
            end else begin
               exp_err = 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_msg(input int dx, input int dy, input logic [DATA_WIDTH-1:0] p);
      msg_valid = 1;
      msg_dest_x = XW'(dx);
      msg_dest_y = YW'(dy);
      msg_payload = p;
   endtask

   task automatic drain(input string name);
      msg_valid = 0;
      flit_ready = 1;
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      chk(name, 64'(sb.size()), 64'd0);
      tick();
      tick();
   endtask

   initial begin
      int base;
      logic [FW-1:0] held;

      // Reset values
      repeat (2) tick();
      chk("rst_flit_valid", 64'(flit_valid), 64'd0);
      chk("rst_flit_out", 64'(flit_out), 64'd0);
      chk("rst_msg_ready", 64'(msg_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pkt_sent", 64'(pkt_sent), 64'd0);
      chk("rst_dest_err", 64'(dest_err), 64'd0);
      rst = 1;
      repeat (2) tick();

      // Single packet latency and format
      flit_ready = 1;
      set_msg(1, 1, 32'hDEADBEEF);
      tick();
      msg_valid = 0;
      @(negedge clk);
      chk("lat_no_head_yet", 64'(flit_valid), 64'd0);
      @(negedge clk);
      chk("lat_head_valid", 64'(flit_valid), 64'd1);
      chk("lat_head", 64'(flit_out[DATA_WIDTH+1:0]), 64'h1_0000_0065);
      @(negedge clk);
      chk("lat_tail", 64'(flit_out[DATA_WIDTH+1:0]), 64'h2_DEAD_BEEF);
      @(negedge clk);
      chk("lat_pkt_sent", 64'(pkt_sent), 64'd1);
      chk("lat_busy", 64'(busy), 64'd0);
      chk("lat_idle", 64'(flit_valid), 64'd0);
      tick();

      // Out-of-range destination is consumed and flagged, next legal one is sent
      set_msg(3, 0, 32'h1234_5678);
      tick();
      msg_valid = 0;
      repeat (3) @(negedge clk);
      chk("drop_no_flit", 64'(flit_valid), 64'd0);
      chk("drop_err", 64'(dest_err), 64'd1);
      tick();
      set_msg(2, 1, 32'hCAFE_0001);
      tick();
      drain("drain_after_drop");
      chk("drop_err_sticky", 64'(dest_err), 64'd1);

      // HEAD held while flit_ready=0,0 then taken
      flit_ready = 0;
      set_msg(0, 2, 32'h0BAD_F00D);
      tick();
      msg_valid = 0;
      tick();
      @(negedge clk);
      held = flit_out;
      chk("hold_head_type", 64'(held[DATA_WIDTH+1:DATA_WIDTH]), 64'd1);
      repeat (2) @(negedge clk);
      chk("hold_head_same", 64'(flit_out), 64'(held));
      tick();
      flit_ready = 1;
      tick();
      flit_ready = 0;
      @(negedge clk);
      chk("hold_tail_next", 64'(flit_out[DATA_WIDTH+1:0]), 64'h2_0BAD_F00D);
      drain("drain_hold");

      // Fill until stall, then full-rate burst
      flit_ready = 0;
      base = n_acc;
      for (int i = 0; i < 8; i++) begin
         set_msg($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
         tick();
      end
      msg_valid = 0;
      chk("fill_accepts", 64'(n_acc - base), 64'(FIFO_DEPTH + 1));
      chk("fill_stall", 64'(msg_ready), 64'd0);
      tick();
      flit_ready = 1;
      for (int i = 0; i < 2*(FIFO_DEPTH + 1); i++) begin
         @(negedge clk);
         chk("burst_valid", 64'(flit_valid), 64'd1);
      end
      drain("drain_burst");

      // Reset mid-packet with entries queued
      flit_ready = 0;
      for (int i = 0; i < 3; i++) begin
         set_msg($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
         tick();
      end
      msg_valid = 0;
      tick();
      flit_ready = 1;
      tick();
      flit_ready = 0;
      @(negedge clk);
      chk("pre_rst_tail", 64'(flit_out[DATA_WIDTH+1:DATA_WIDTH]), 64'd2);
      tick();
      rst = 0;
      sb.delete();
      exp_pkt = 0;
      exp_err = 0;
      #1;
      chk("mid_rst_valid", 64'(flit_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_ready", 64'(msg_ready), 64'd0);
      repeat (2) tick();
      rst = 1;
      flit_ready = 1;
      repeat (4) tick();
      chk("post_rst_valid", 64'(flit_valid), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_pkt", 64'(pkt_sent), 64'd0);

      // Randomised traffic with random backpressure
      for (int i = 0; i < 500; i++) begin
         msg_valid = ($urandom_range(0, 2) != 0);
         msg_dest_x = ($urandom_range(0, 31) == 0) ? XW'(3) : XW'($urandom_range(0, 2));
         msg_dest_y = ($urandom_range(0, 31) == 0) ? YW'(3) : YW'($urandom_range(0, 2));
         msg_payload = $urandom;
         flit_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      drain("drain_random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
